// File: rtl/sdp_ram_rdata.sv
// Simple-dual-port RAM with byte-enable writes, registered read data, a 1- or 2-stage
// read pipeline, selectable collision policy and a read-valid strobe.
module sdp_ram_rdata #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 2,
  parameter int unsigned           READ_LATENCY = 1,
  parameter bit                    WRITE_FIRST  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sdp_ram_rdata: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "sdp_ram_rdata: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  collide;

  logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;
  logic                  s1_valid_d, s1_valid_q;

  // Read word seen by this edge, with the write-first byte merge on collision.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_word = mem[raddr];
    collide = wen && (waddr == raddr);
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (WRITE_FIRST && collide && wstrb[i]) begin
        rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // NOTE: the array has no reset; it is plain storage and must map onto RAM macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (wen && wstrb[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = ren;
    if (ren) begin
      s1_data_d = rd_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= RESET_VALUE;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_d, s2_data_q;
    logic                  s2_valid_d, s2_valid_q;

    // Stage 2 only moves when stage 1 retires a result, so rdata holds otherwise.
    always_comb begin
      s2_data_d  = s2_data_q;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q  <= RESET_VALUE;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign rdata  = s2_data_q;
    assign rvalid = s2_valid_q;
  end else begin : g_lat1
    assign rdata  = s1_data_q;
    assign rvalid = s1_valid_q;
  end

endmodule
